// File: rtl/pid_sched_pkg.sv
// Shared types and constants for the PID loop sequencer.
package pid_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RAMP = 2'b01,
    RUN  = 2'b10
  } sched_state_t;

  localparam int TICK_BITS_FAST = 15;
  localparam int TICK_BITS_SLOW = 20;

  // Unsigned operands widened by one bit so the difference is a valid 13-bit signed value.
  function automatic logic [12:0] raw_diff(input logic [11:0] a, input logic [11:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

endpackage

// File: rtl/pid_sched_cad_mon.sv
// Cadence monitor: counts ticks without pedal pulses and pulses seen while idle.
module cad_mon #(
  parameter int CAD_TIMEOUT_TICKS = 8,
  parameter int CAD_START_PULSES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pid_tick,
  input  logic cadence_rise,
  input  logic in_idle,
  output logic timeout,
  output logic start_ok
);

  logic [3:0] miss_cnt;
  logic [3:0] start_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt  <= 4'd0;
      start_cnt <= 4'd0;
    end else begin
      // A pedal pulse in the same cycle as a tick keeps assist alive.
      if (cadence_rise)
        miss_cnt <= 4'd0;
      else if (pid_tick && (miss_cnt < 4'(CAD_TIMEOUT_TICKS)))
        miss_cnt <= miss_cnt + 4'd1;

      if (!in_idle)
        start_cnt <= 4'd0;
      else if (cadence_rise && (start_cnt != 4'hF))
        start_cnt <= start_cnt + 4'd1;
    end
  end

  // Both flags look ahead to the post-update count so the FSM reacts next cycle.
  assign timeout  = pid_tick && !cadence_rise && (miss_cnt >= 4'(CAD_TIMEOUT_TICKS - 1));
  assign start_ok = in_idle && cadence_rise && (start_cnt >= 4'(CAD_START_PULSES - 1));

endmodule

// File: rtl/pid_sched.sv
// PID loop sequencer: loop tick, pedaling detect, soft-start target and error register.
// Optional PID_SCHED_ERR_AVG_EN: error is the two-sample average of the raw difference.
module pid_sched
  import pid_sched_pkg::*;
#(
  parameter bit          FAST_SIM          = 1'b1,
  parameter logic [11:0] RAMP_STEP         = 12'd16,
  parameter int          CAD_TIMEOUT_TICKS = 8,
  parameter int          CAD_START_PULSES  = 2,
  parameter int          TICK_BITS         = FAST_SIM ? TICK_BITS_FAST : TICK_BITS_SLOW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] target_curr,
  input  logic [11:0] avg_curr,
  input  logic        curr_vld,
  input  logic        cadence_rise,
  output logic        pid_tick,
  output logic [12:0] error,
  output logic        not_pedaling,
  output logic [11:0] eff_target,
  output logic [1:0]  state
);

  logic [TICK_BITS-1:0] tick_cnt;
  sched_state_t         st, st_nxt;
  logic [11:0]          eff_nxt;
  logic [12:0]          err_nxt, err_new, raw;
  logic [12:0]          ramp_sum;
  logic                 timeout, start_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick_cnt + {{(TICK_BITS-1){1'b0}}, 1'b1};
  end

  assign pid_tick = &tick_cnt;

  cad_mon #(
    .CAD_TIMEOUT_TICKS(CAD_TIMEOUT_TICKS),
    .CAD_START_PULSES (CAD_START_PULSES)
  ) u_cad_mon (
    .clk         (clk),
    .rst_n       (rst_n),
    .pid_tick    (pid_tick),
    .cadence_rise(cadence_rise),
    .in_idle     (st == IDLE),
    .timeout     (timeout),
    .start_ok    (start_ok)
  );

  assign raw = raw_diff(eff_target, avg_curr);

`ifdef PID_SCHED_ERR_AVG_EN
  logic [12:0] prev_diff;
  logic [13:0] avg_sum;

  assign avg_sum = {raw[12], raw} + {prev_diff[12], prev_diff};
  assign err_new = avg_sum[13:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             prev_diff <= '0;
    else if (st == IDLE)    prev_diff <= '0;
    else if (curr_vld)      prev_diff <= raw;
  end
`else
  assign err_new = raw;
`endif

  // 13-bit sum so a step past 0xFFF is seen as >= target rather than wrapping.
  assign ramp_sum = {1'b0, eff_target} + {1'b0, RAMP_STEP};

  always_comb begin
    st_nxt  = st;
    eff_nxt = eff_target;
    err_nxt = error;
    case (st)
      IDLE: begin
        eff_nxt = '0;
        err_nxt = '0;
        if (start_ok) st_nxt = RAMP;
      end
      RAMP: begin
        if (pid_tick) begin
          if (ramp_sum >= {1'b0, target_curr}) begin
            eff_nxt = target_curr;
            st_nxt  = RUN;
          end else begin
            eff_nxt = ramp_sum[11:0];
          end
        end
      end
      RUN:     eff_nxt = target_curr;
      default: st_nxt  = IDLE;
    endcase

    if ((st != IDLE) && curr_vld) err_nxt = err_new;

    // Loss of cadence overrides any ramp step or error update in the same cycle.
    if ((st != IDLE) && timeout) begin
      st_nxt  = IDLE;
      eff_nxt = '0;
      err_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      eff_target   <= '0;
      error        <= '0;
      not_pedaling <= 1'b1;
    end else begin
      st           <= st_nxt;
      eff_target   <= eff_nxt;
      error        <= err_nxt;
      not_pedaling <= (st_nxt == IDLE);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pid_sched.sv
// Scoreboard bench for pid_sched; tick width shortened to 6 bits to keep runs short.
module tb_pid_sched;

  localparam int TB_BITS = 6;
  localparam int PERIOD  = 64;

  logic        clk, rst_n;
  logic [11:0] target_curr, avg_curr;
  logic        curr_vld, cadence_rise;
  logic        pid_tick, not_pedaling;
  logic [12:0] error;
  logic [11:0] eff_target;
  logic [1:0]  state;

  pid_sched #(
    .FAST_SIM(1'b1), .RAMP_STEP(12'd16), .CAD_TIMEOUT_TICKS(8),
    .CAD_START_PULSES(2), .TICK_BITS(TB_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .target_curr(target_curr), .avg_curr(avg_curr),
    .curr_vld(curr_vld), .cadence_rise(cadence_rise), .pid_tick(pid_tick),
    .error(error), .not_pedaling(not_pedaling), .eff_target(eff_target), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [1:0] st; logic [11:0] eff; } tick_exp_t;

  tick_exp_t   tick_q[$];
  logic [12:0] err_q[$];
  tick_exp_t   mon_e;
  logic [12:0] mon_err;
  logic        mon_tick_d, mon_vld_d;
  logic [12:0] last_err;
  int          checks, errors, model_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the falling edge inside the next tick cycle.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (pid_tick !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    chk("tick_wait", {31'd0, pid_tick}, 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic cad_pulse();
    @(posedge clk); #1 cadence_rise = 1'b1;
    @(posedge clk); #1 cadence_rise = 1'b0;
  endtask

  task automatic start_assist();
    cad_pulse();
    @(negedge clk);
    chk("one_pulse_idle", {30'd0, state}, 32'd0);
    cad_pulse();
    @(negedge clk);
    chk("start_ramp", {30'd0, state}, 32'd1);
    chk("start_np", {31'd0, not_pedaling}, 32'd0);
  endtask

  task automatic push_tick(input logic [1:0] s, input logic [11:0] e);
    tick_exp_t t;
    t.st = s; t.eff = e;
    tick_q.push_back(t);
  endtask

  task automatic send_curr(input int eff, input logic [11:0] a);
    int raw, exp;
    raw = eff - int'(a);
`ifdef PID_SCHED_ERR_AVG_EN
    exp = (raw + model_prev) >>> 1;
    model_prev = raw;
`else
    exp = raw;
`endif
    @(posedge clk); #1;
    avg_curr = a; curr_vld = 1'b1;
    err_q.push_back(exp[12:0]);
    last_err = exp[12:0];
    @(posedge clk); #1 curr_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    model_prev = 0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    checks = 0; errors = 0; model_prev = 0; last_err = '0;
    mon_tick_d = 1'b0; mon_vld_d = 1'b0;
    rst_n = 1'b0; target_curr = '0; avg_curr = '0; curr_vld = 1'b0; cadence_rise = 1'b0;

    fork
      begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mon_tick_d = 1'b0; mon_vld_d = 1'b0;
        end else begin
          if (mon_tick_d && tick_q.size() > 0) begin
            mon_e = tick_q.pop_front();
            chk("tick_state", {30'd0, state}, {30'd0, mon_e.st});
            chk("tick_eff", {20'd0, eff_target}, {20'd0, mon_e.eff});
          end
          if (mon_vld_d && err_q.size() > 0) begin
            mon_err = err_q.pop_front();
            chk("error", {19'd0, error}, {19'd0, mon_err});
          end
          mon_tick_d = pid_tick;
          mon_vld_d  = curr_vld;
        end
      end
    join_none

    // Reset values and tick period
    #12;
    chk("rst_np", {31'd0, not_pedaling}, 32'd1);
    chk("rst_err", {19'd0, error}, 32'd0);
    chk("rst_eff", {20'd0, eff_target}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_tick", {31'd0, pid_tick}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_tick();
    for (int k = 0; k < 2; k++) begin
      cnt = 1;
      @(negedge clk);
      while (pid_tick !== 1'b1 && cnt < 2 * PERIOD) begin
        @(negedge clk);
        cnt++;
      end
      chk("tick_period", cnt, PERIOD);
    end
    chk("idle_no_cad", {30'd0, state}, 32'd0);
    chk("idle_np", {31'd0, not_pedaling}, 32'd1);

    // Soft start to 100
    target_curr = 12'd100;
    wait_tick();
    start_assist();
    for (int i = 1; i <= 6; i++) push_tick(2'd1, 12'(16 * i));
    push_tick(2'd2, 12'd100);
    wait_ticks(7);
    cad_pulse();
    chk("ramp_q_empty", tick_q.size(), 32'd0);

    // RUN error path
    target_curr = 12'h300;
    cyc(3);
    send_curr(12'h300, 12'h2B0);
    send_curr(12'h300, 12'h350);
    cyc(5);
    @(negedge clk);
    chk("err_hold", {19'd0, error}, {19'd0, last_err});

    // Cadence timeout after 8 silent ticks
    wait_tick();
    cad_pulse();
    for (int i = 0; i < 7; i++) push_tick(2'd2, 12'h300);
    push_tick(2'd0, 12'd0);
    wait_ticks(8);
    @(negedge clk);
    chk("to_np", {31'd0, not_pedaling}, 32'd1);
    chk("to_err", {19'd0, error}, 32'd0);
    model_prev = 0;

    // Pedal pulse coincident with the 8th tick keeps RUN
    target_curr = 12'd32;
    wait_tick();
    start_assist();
    push_tick(2'd1, 12'd16);
    push_tick(2'd2, 12'd32);
    wait_ticks(2);
    wait_tick();
    cad_pulse();
    for (int i = 0; i < 8; i++) push_tick(2'd2, 12'd32);
    wait_ticks(7);
    repeat (PERIOD) @(posedge clk);
    #1 cadence_rise = 1'b1;
    @(negedge clk);
    chk("coincide_tick", {31'd0, pid_tick}, 32'd1);
    @(posedge clk); #1 cadence_rise = 1'b0;
    @(negedge clk);
    chk("coincide_run", {30'd0, state}, 32'd2);
    chk("coincide_np", {31'd0, not_pedaling}, 32'd0);
    wait_ticks(7);
    @(negedge clk);
    chk("clear_wins_run", {30'd0, state}, 32'd2);
    chk("coincide_q_empty", tick_q.size(), 32'd0);

    // Full-scale target: no wrap past 0xFF0
    do_reset();
    target_curr = 12'hFFF;
    wait_tick();
    start_assist();
    for (int i = 1; i <= 255; i++) push_tick(2'd1, 12'(16 * i));
    push_tick(2'd2, 12'hFFF);
    push_tick(2'd2, 12'hFFF);
    for (int i = 0; i < 257; i++) begin
      wait_tick();
      cad_pulse();
    end
    chk("full_q_empty", tick_q.size(), 32'd0);

    // Async reset mid-ramp
    do_reset();
    target_curr = 12'd100;
    wait_tick();
    start_assist();
    push_tick(2'd1, 12'd16);
    push_tick(2'd1, 12'd32);
    push_tick(2'd1, 12'd48);
    wait_ticks(3);
    send_curr(48, 12'h010);
    cyc(2);
    @(negedge clk);
    chk("pre_rst_eff", {20'd0, eff_target}, 32'd48);
    #2 rst_n = 1'b0;
    model_prev = 0;
    #1;
    chk("arst_np", {31'd0, not_pedaling}, 32'd1);
    chk("arst_err", {19'd0, error}, 32'd0);
    chk("arst_eff", {20'd0, eff_target}, 32'd0);
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_tick", {31'd0, pid_tick}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_tick();
    start_assist();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
